// File: rtl/rr_pixel_search.sv
// Round-robin search over NB core done flags; hands the chosen pixel to the frame-buffer writer.
// Optional RR_SEARCH_STATS_EN adds grant_count/stall_count statistics outputs.
module rr_pixel_search #(
  parameter int NB = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = $clog2(NB)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             search_en,
  input  logic [NB*AW-1:0] cataddresses,
  input  logic [NB*DW-1:0] catpixels,
  input  logic [NB-1:0]    done,
  input  logic             wr_ready,
  output logic             found,
  output logic [AW-1:0]    sel_address,
  output logic [DW-1:0]    sel_data,
  output logic [IW-1:0]    sel_idx,
  output logic [NB-1:0]    mask
`ifdef RR_SEARCH_STATS_EN
  ,
  output logic [15:0]      grant_count,
  output logic [15:0]      stall_count
`endif
);

  typedef enum logic [1:0] {SCAN = 2'd0, HOLD = 2'd1, ACK = 2'd2} state_e;

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] sel_idx_q;
  logic          found_q;
  logic [AW-1:0] sel_address_q;
  logic [DW-1:0] sel_data_q;
  logic [NB-1:0] mask_q;

  logic [NB-1:0] rot_d;
  logic          hit_d;
  logic [IW-1:0] offset_d;
  logic [IW:0]   sum_d;
  logic [IW-1:0] grant_d;
  logic [AW-1:0] grant_addr_d;
  logic [DW-1:0] grant_data_d;

  // Rotate done so ptr sits at bit 0; the lowest set bit is the first core at or after ptr.
  always_comb begin
    rot_d    = NB'({done, done} >> ptr_q);
    hit_d    = 1'b0;
    offset_d = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      if (rot_d[k]) begin
        hit_d    = 1'b1;
        offset_d = IW'(k);
      end
    end
    sum_d = {1'b0, ptr_q} + {1'b0, offset_d};
    if (sum_d >= (IW+1)'(NB)) begin
      sum_d = sum_d - (IW+1)'(NB);
    end
    grant_d = sum_d[IW-1:0];
  end

  always_comb begin
    grant_addr_d = '0;
    grant_data_d = '0;
    for (int k = 0; k < NB; k++) begin
      if (grant_d == IW'(k)) begin
        grant_addr_d = cataddresses[k*AW +: AW];
        grant_data_d = catpixels[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SCAN;
      ptr_q         <= '0;
      sel_idx_q     <= '0;
      found_q       <= 1'b0;
      sel_address_q <= '0;
      sel_data_q    <= '0;
      mask_q        <= '0;
    end else begin
      case (state_q)
        SCAN: begin
          mask_q  <= '0;
          found_q <= 1'b0;
          if (search_en && hit_d) begin
            sel_idx_q     <= grant_d;
            sel_address_q <= grant_addr_d;
            sel_data_q    <= grant_data_d;
            found_q       <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          // search_en deliberately ignored: an accepted grant always completes.
          if (wr_ready) begin
            found_q <= 1'b0;
            mask_q  <= NB'(1) << sel_idx_q;
            ptr_q   <= (sel_idx_q == IW'(NB - 1)) ? '0 : sel_idx_q + 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          mask_q  <= '0;
          state_q <= SCAN;
        end
        default: begin
          mask_q  <= '0;
          found_q <= 1'b0;
          state_q <= SCAN;
        end
      endcase
    end
  end

  assign found       = found_q;
  assign sel_address = sel_address_q;
  assign sel_data    = sel_data_q;
  assign sel_idx     = sel_idx_q;
  assign mask        = mask_q;

`ifdef RR_SEARCH_STATS_EN
  logic [15:0] grant_count_q;
  logic [15:0] stall_count_q;

  // Grant count wraps; stall count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count_q <= '0;
      stall_count_q <= '0;
    end else if (state_q == HOLD) begin
      if (wr_ready) begin
        grant_count_q <= grant_count_q + 16'd1;
      end else if (stall_count_q != 16'hFFFF) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  assign grant_count = grant_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/rr_pixel_search.md
Name: rr_pixel_search

Overview:
- Parametrised successor to the single-width core result search. Scans NB fractal cores' done flags with a rotating round-robin pointer and selects one finished core.
- Presents that core's pixel address and data to the frame-buffer writer through a valid/ready handshake.
- After the write is accepted, returns a one-cycle one-hot acknowledge mask so the core can clear done and start its next pixel.
- Sits between the core array and the memory write port.

Parameters:
- NB, 4, number of cores/channels (>=2).
- AW, 32, address width per core.
- DW, 32, pixel data width per core.
- IW, $clog2(NB), width of the grant index.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- search_en  input  1  high permits new grants; low pauses scanning.
- cataddresses  input  NB*AW  concatenated core addresses; core i at [i*AW +: AW].
- catpixels  input  NB*DW  concatenated core pixel data; core i at [i*DW +: DW].
- done  input  NB  per-core result-ready flags.
- wr_ready  input  1  writer accepts sel_* this cycle.
- found  output  1  sel_address/sel_data valid.
- sel_address  output  AW  latched address of the granted core.
- sel_data  output  DW  latched pixel of the granted core.
- sel_idx  output  IW  index of the granted core.
- mask  output  NB  one-hot acknowledge, asserted one cycle per completed transfer.

Behaviour:
- Reset (rst=1 at posedge): state=SCAN, ptr=0. found=0, sel_address=0, sel_data=0, sel_idx=0, mask=0. Reset overrides everything, including mid-HOLD; the pending transfer is dropped with no mask pulse.
- State SCAN, when search_en=1 and done!=0:
  - g = first set bit of done, searching ptr, ptr+1, … NB-1, 0, … ptr-1 (wrap-around).
  - At the next edge: latch sel_address/sel_data from core g, sel_idx=g, found=1, go to HOLD.
- SCAN latency: done[g] high before edge k gives found=1 after edge k (one cycle).
- State SCAN with search_en=0 or done==0: outputs hold, found=0, mask=0.
- State HOLD:
  - found=1; sel_* stable and independent of input changes, including done dropping.
  - search_en is ignored; an in-flight grant always completes.
  - On an edge with wr_ready=1: go to ACK, found=0, mask=1<<sel_idx, ptr=(sel_idx+1) mod NB. At sel_idx=NB-1, ptr wraps to 0.
  - wr_ready=0: remain in HOLD indefinitely.
- State ACK, exactly one cycle:
  - mask is one-hot for that cycle, then returns to 0. Go to SCAN.
  - Cores must drop done within the ACK cycle. A done still high at SCAN is treated as a new result.
- Throughput: with wr_ready tied high, at most one grant per 3 cycles (SCAN→HOLD→ACK).
- Fairness: a core with done held high is granted within NB grants.
- Simultaneous done bits: only the first from ptr is served; the others wait.
- Non-power-of-two NB: ptr increment wraps explicitly at NB, not at 2^IW.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro RR_SEARCH_STATS_EN.
- Defined:
  - Adds output port grant_count [15:0]: counts completed transfers (HOLD with wr_ready=1).
  - Reset to 0; wraps 16'hFFFF→0.
  - Adds output port stall_count [15:0]: counts cycles in HOLD with wr_ready=0. Saturates at 16'hFFFF and clears on reset.
- Undefined: neither port exists; core behaviour is identical.

Test Plan:
- Reset, NB=4, done=4'b1000, wr_ready=1, search_en=1:
  - found=1 one cycle after reset release, sel_idx=3, sel_address=cataddresses[127:96].
  - mask=4'b1000 two cycles later.
  - ptr wraps to 0.
- done=4'b1111 held, bench clears done[i] on mask[i] and re-raises it 3 cycles later:
  - grant order 0,1,2,3,0.
  - found pulses exactly every 3 cycles.
- search_en=0 for 8 cycles with done=4'b0010: found stays 0. Raise search_en: found=1 next cycle, sel_idx=1.
- In HOLD with wr_ready=0 for 5 cycles while sel_idx=2:
  - change catpixels[95:64] and drop done[2]; sel_data unchanged, found=1.
  - raise wr_ready: mask=4'b0100 next cycle.
- Assert rst mid-HOLD: found=0, mask=0 after the edge, no mask pulse. The next grant starts from core 0.
- RR_SEARCH_STATS_EN defined, 3 transfers with 4 total stall cycles: grant_count=3, stall_count=4.
